uart_rx: RTL

8N1 UART receiver running on clock100. Turns the serial rx line into byte-wide data plus a one-cycle data_ready strobe. Sits directly upstream of uart_mem_if: data and data_ready connect straight to its data_in and data_ready. The character memory write path is therefore fed from the host serial link with no extra glue.

---
 rtl/uart_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver
//
// Converts the asynchronous serial line into bytes. The line is first passed
// through a flip-flop synchroniser; the framing FSM samples the synchronised
// bit (rxs) at the middle of every bit period. A byte is published on `data`
// only when its stop bit reads high. A low stop bit raises `framing_error`
// instead. The FSM then waits in BREAK until the line returns high, so a line
// held low can never produce repeated frames.
//
// Handshake: data_ready is a one-cycle strobe with no backpressure. data is
// valid in the strobe cycle and holds its value until the next good frame.
//
// Parameters
//   CLKS_PER_BIT  clock100 cycles per bit (legal 4..65535)
//   SYNC_STAGES   synchroniser depth (>= 2)
//
// Ports
//   clock100       in   system clock, all logic on the rising edge
//   reset_n        in   asynchronous active-low reset
//   rx             in   serial line, idle high, asynchronous to clock100
//   data[7:0]      out  last correctly framed byte
//   data_ready     out  one-cycle pulse when data is updated
//   framing_error  out  one-cycle pulse when the stop bit is sampled low
//   busy           out  high from start-bit detection until back in IDLE
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clock100,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   data_ready_q, data_ready_d;
    logic                   framing_error_q, framing_error_d;
    logic                   rxs;

    // Synchroniser: bit 0 captures the raw line, the top bit feeds the FSM.
    assign rxs    = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};

    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            sync_q          <= '1;
            clk_cnt_q       <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            clk_cnt_q       <= clk_cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            data_q          <= data_d;
            data_ready_q    <= data_ready_d;
            framing_error_q <= framing_error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        clk_cnt_d       = clk_cnt_q + CW'(1);
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        data_d          = data_q;
        data_ready_d    = 1'b0;
        framing_error_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end

            // Wait half a bit so every later sample lands mid-bit; a start
            // bit that is gone by then was a glitch.
            S_START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rxs ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rxs;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            // Leaving at mid-stop-bit lets a following start edge be seen
            // anywhere in the second half of the stop bit.
            S_STOP: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d = '0;
                    if (rxs) begin
                        data_d       = shift_q;
                        data_ready_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                clk_cnt_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                clk_cnt_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign data          = data_q;
    assign data_ready    = data_ready_q;
    assign framing_error = framing_error_q;
    assign busy          = (state_q != S_IDLE);

endmodule
